// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the round-robin tristate bus arbiter.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } arb_state_t;

    function automatic int arb_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request strictly after i_last, wrapping.
module rr_pick
    import bus_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = arb_idx_w(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_last,
    output logic [IW-1:0] o_pick,
    output logic          o_any
);

    always_comb begin
        logic w_found;
        int   w_idx;
        o_pick  = '0;
        w_found = 1'b0;
        w_idx   = 0;
        // i_last itself is visited last, so the previous owner has lowest priority
        for (int k = 1; k <= N; k++) begin
            w_idx = (int'(i_last) + k) % N;
            if (!w_found && i_req[w_idx]) begin
                o_pick  = IW'(w_idx);
                w_found = 1'b1;
            end
        end
    end

    assign o_any = |i_req;

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner of a shared tristate bus: one-hot enables, bounded tenure,
// and all-disabled turnaround gaps so no two drivers ever overlap.
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int N          = 4,
    parameter int MAX_HOLD   = 8,
    parameter int TURNAROUND = 1
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic [N-1:0]            i_req,
    output logic [N-1:0]            o_en,
    output logic [arb_idx_w(N)-1:0] o_grant_id,
    output logic                    o_busy
);

    localparam int IW       = arb_idx_w(N);
    localparam int HW       = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam int HOLD_LIM = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;
    localparam int TW       = 3;

    arb_state_t     r_state;
    logic [N-1:0]   r_en;
    logic [IW-1:0]  r_gid;
    logic [IW-1:0]  r_last;
    logic           r_busy;
    logic [HW-1:0]  r_hold;
    logic [TW-1:0]  r_turn;

    logic [IW-1:0]  w_pick;
    logic           w_any;
    logic [N-1:0]   w_pick_oh;
    logic           w_hold_done;
    logic           w_turn_last;

    rr_pick #(.N(N), .IW(IW)) u_pick (
        .i_req  (i_req),
        .i_last (r_last),
        .o_pick (w_pick),
        .o_any  (w_any)
    );

    assign w_pick_oh   = {{(N-1){1'b0}}, 1'b1} << w_pick;
    // Counter clears on grant entry, so the last granted cycle sees MAX_HOLD-1
    assign w_hold_done = (MAX_HOLD != 0) && (r_hold == HW'(HOLD_LIM));
    assign w_turn_last = (r_turn == TW'(TURNAROUND - 1));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_en    <= '0;
            r_gid   <= '0;
            r_busy  <= 1'b0;
            r_hold  <= '0;
            r_turn  <= '0;
            r_last  <= IW'(N - 1);
        end else begin
            unique case (r_state)
                IDLE, TURN: begin
                    if (r_state == IDLE || w_turn_last) begin
                        if (w_any) begin
                            r_state <= GRANT;
                            r_en    <= w_pick_oh;
                            r_gid   <= w_pick;
                            r_last  <= w_pick;
                            r_busy  <= 1'b1;
                            r_hold  <= '0;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_turn <= r_turn + 1'b1;
                    end
                end
                GRANT: begin
                    if (!i_req[r_gid] || w_hold_done) begin
                        r_state <= TURN;
                        r_en    <= '0;
                        r_busy  <= 1'b0;
                        r_turn  <= '0;
                    end else if (r_hold != '1) begin
                        r_hold <= r_hold + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_en    <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    a_en_onehot0: assert property (@(posedge i_clk) $onehot0(r_en));

    assign o_en       = r_en;
    assign o_grant_id = r_gid;
    assign o_busy     = r_busy;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed scoreboard bench: four constant tristate drivers share bus y under arbiter control.
module tb_bus_arbiter;

    localparam int N = 4;

    typedef struct {
        logic [N-1:0] en;
        int           gid;
    } exp_t;

    logic         clk;
    logic         reset;
    logic [N-1:0] req;
    logic [N-1:0] en;
    logic [1:0]   grant_id;
    logic         busy;
    tri   [3:0]   y;

    int   total = 0;
    int   bad   = 0;
    exp_t q[$];

    bus_arbiter #(.N(N), .MAX_HOLD(3), .TURNAROUND(1)) dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_req      (req),
        .o_en       (en),
        .o_grant_id (grant_id),
        .o_busy     (busy)
    );

    for (genvar i = 0; i < N; i++) begin : g_drv
        assign y = en[i] ? 4'(i + 1) : 4'bz;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Row semantics: inputs applied this cycle, outputs expected this same cycle
    task automatic step(input int n, input logic rst, input logic [N-1:0] r,
                        input logic [N-1:0] e, input int g);
        exp_t x;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            reset = rst;
            req   = r;
            x.en  = e;
            x.gid = g;
            q.push_back(x);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t x;
            logic xb;
            x  = q.pop_front();
            xb = |x.en;
            total++;
            if (en !== x.en) begin
                bad++;
                $display("FAIL en: got %b want %b at %0t", en, x.en, $time);
            end
            total++;
            if (busy !== xb) begin
                bad++;
                $display("FAIL busy: got %b want %b at %0t", busy, xb, $time);
            end
            if (xb) begin
                total++;
                if (grant_id !== 2'(x.gid)) begin
                    bad++;
                    $display("FAIL grant_id: got %0d want %0d at %0t", grant_id, x.gid, $time);
                end
                total++;
                if (y !== 4'(x.gid + 1)) begin
                    bad++;
                    $display("FAIL bus_y: got %h want %h at %0t", y, 4'(x.gid + 1), $time);
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        req   = '0;
        @(posedge clk);
        // reset then idle
        step(3, 1'b0, 4'b0000, 4'b0000, 0);
        // single requester 2, held two cycles
        step(1, 1'b0, 4'b0100, 4'b0000, 0);
        step(1, 1'b0, 4'b0100, 4'b0100, 2);
        step(1, 1'b0, 4'b0000, 4'b0100, 2);
        step(2, 1'b0, 4'b0000, 4'b0000, 0);
        // reset so the all-request rotation starts at 0
        step(1, 1'b1, 4'b0000, 4'b0000, 0);
        step(1, 1'b0, 4'b0000, 4'b0000, 0);
        step(1, 1'b0, 4'b1111, 4'b0000, 0);
        step(3, 1'b0, 4'b1111, 4'b0001, 0);
        step(1, 1'b0, 4'b1111, 4'b0000, 0);
        step(3, 1'b0, 4'b1111, 4'b0010, 1);
        step(1, 1'b0, 4'b1111, 4'b0000, 0);
        step(3, 1'b0, 4'b1111, 4'b0100, 2);
        step(1, 1'b0, 4'b1111, 4'b0000, 0);
        step(3, 1'b0, 4'b1111, 4'b1000, 3);
        step(1, 1'b0, 4'b1111, 4'b0000, 0);
        step(2, 1'b0, 4'b1111, 4'b0001, 0);
        // requester 0 alone: forced release, float, re-grant to 0
        step(1, 1'b0, 4'b0001, 4'b0001, 0);
        step(1, 1'b0, 4'b0001, 4'b0000, 0);
        step(3, 1'b0, 4'b0001, 4'b0001, 0);
        step(1, 1'b0, 4'b0001, 4'b0000, 0);
        step(1, 1'b0, 4'b0001, 4'b0001, 0);
        // reset in the second cycle of a tenure, then index 0 wins first
        step(1, 1'b1, 4'b0001, 4'b0001, 0);
        step(1, 1'b0, 4'b1111, 4'b0000, 0);
        // owner drops while 2 is pending
        step(1, 1'b0, 4'b0100, 4'b0001, 0);
        step(1, 1'b0, 4'b0100, 4'b0000, 0);
        step(1, 1'b0, 4'b0100, 4'b0100, 2);
        step(1, 1'b0, 4'b0000, 4'b0100, 2);
        step(3, 1'b0, 4'b0000, 4'b0000, 0);
        @(posedge clk);
        @(negedge clk);
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
